baked_cb_config_loader: RTL and testbench
=========================================

Name: baked_cb_config_loader

Overview:
- Sequencer that loads configuration bitstreams into a daisy-chained group of baked connection blocks.
- Accepts configuration words over a valid/ready stream and serialises them LSB-first onto the chain's `shift_in`, gating the chain with `cen`.
- Issues a one-cycle `set_in` commit once exactly CHAIN_LEN bits have been shifted.
- Returns the old chain contents, captured from `shift_out`, as a readback bit stream.

Parameters:
- CHAIN_LEN, 256, total configuration bits in the chain; legal range ≥1.
- WORD, 32, width of input configuration words; legal range ≥1.
- CNT_W, $clog2(CHAIN_LEN+1), width of the chain bit counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin a load; sampled only in IDLE
- abort  input  1  cancel the load from any state
- word_in  input  WORD  configuration word, bit 0 shifted first
- word_valid  input  1  word_in valid
- word_ready  output  1  loader can accept word_in this cycle
- cen  output  1  chain shift enable
- shift_in  output  1  serial bit into the chain
- set_in  output  1  commit pulse to the chain
- shift_out  input  1  serial bit from the chain tail
- rb_valid  output  1  rb_bit valid
- rb_bit  output  1  readback bit (registered copy of shift_out)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse, load committed
- aborted  output  1  one-cycle pulse, load cancelled

Behaviour:
- Reset: every output is 0. State is IDLE; all counters and the shift register are cleared.
- States: IDLE, FETCH, SHIFT, COMMIT, FINISH.
- IDLE:
  - start=1 → FETCH and clear `bits_done`.
  - start is ignored in every other state.
- FETCH:
  - word_ready=1, cen=0.
  - On word_valid&&word_ready, load `sreg` ← word_in and `nbits` ← min(WORD, CHAIN_LEN − bits_done), then go to SHIFT.
  - A word is consumed in one cycle; the next word cannot be accepted in the same cycle.
- SHIFT:
  - Each cycle: cen=1, shift_in=sreg[0], sreg>>=1, nbits−=1, bits_done+=1.
  - When nbits reaches 1 in this cycle (last bit of the word):
    - bits_done+1==CHAIN_LEN → COMMIT;
    - otherwise → FETCH.
  - Unused upper bits of the final partial word are discarded.
- Throughput: WORD+1 cycles per full word. Shifting never stalls mid-word.
- COMMIT:
  - cen=0, set_in=1 for exactly one cycle, then FINISH.
  - set_in is never asserted in the same cycle as cen.
- FINISH: done=1 for one cycle, then IDLE.
- Readback:
  - In every cycle with cen=1, register rb_bit←shift_out and rb_valid←1 on the next cycle; otherwise rb_valid←0.
  - Latency: 1 cycle. Exactly CHAIN_LEN rb_valid pulses per completed load.
- Abort:
  - abort=1 in any non-IDLE state forces IDLE on the next edge with aborted=1 for one cycle.
  - cen, set_in and word_ready are 0 from that edge onward; no set_in is issued.
  - The chain contents are undefined after an abort, and the partial word is dropped.
  - abort in IDLE: no effect, no aborted pulse.
  - abort takes priority over start, word acceptance and COMMIT.
- Reset mid-load: asynchronous clear to IDLE; outputs drop immediately, with no set_in and no done.
- Registered outputs: cen, shift_in, set_in, done and aborted are glitch-free to the chain.
- Counter: bits_done never exceeds CHAIN_LEN. CHAIN_LEN=1 yields one word, one shift, then commit.

Test Plan:
- CHAIN_LEN=10, WORD=4, words 0xA, 0x5, 0x3 presented back-to-back:
  - shift_in sequence 0,1,0,1,1,0,1,0,1,1;
  - exactly 10 cen cycles, and word_ready high in 3 separate cycles;
  - set_in one cycle after the last cen, done the cycle after set_in.
- Chain preloaded 0b1111000011 with the model chain wired shift_out←tail: rb_bit stream equals the old contents tail-first, 10 rb_valid pulses each 1 cycle after cen.
- word_valid gaps of 3 idle cycles between words: cen stays 0 during the gaps, the shift_in sequence is unchanged, and the total number of cen cycles is still 10.
- abort asserted on the 6th cen cycle:
  - next cycle cen=0 and aborted=1;
  - no set_in and no done; state returns to IDLE;
  - a subsequent start completes a full load normally.
- rst pulsed asynchronously mid-SHIFT: all outputs 0 before the next clk edge; start after reset performs a clean 10-bit load.
- start held high throughout a load: only one load occurs; start re-sampled in IDLE after done launches the second load.

Source files
------------

// File: rtl/baked_cb_config_loader.sv
// ---------------------------------------------------------------------------
// baked_cb_config_loader
//
// Loads a configuration bitstream into a daisy chain of baked connection
// blocks. Configuration words arrive on a valid/ready stream. Each word is
// shifted LSB-first onto shift_in while cen is high. Once exactly CHAIN_LEN
// bits have been shifted, a single set_in pulse commits the chain. The bits
// that fall out of the chain tail (shift_out) are returned one cycle later as
// a readback stream on rb_valid / rb_bit.
//
// Handshake: a word is transferred on a rising clk edge where word_valid and
// word_ready are both high. word_ready is registered and only high in FETCH.
// word_valid may be raised or dropped at any time and does not depend on
// word_ready.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a load (sampled only in IDLE)
//   abort               cancel a load from any non-IDLE state
//   word_in/word_valid  configuration word stream, word_ready back-pressure
//   cen, shift_in       chain shift enable and serial data into the chain
//   set_in              one-cycle commit pulse to the chain
//   shift_out           serial data from the chain tail
//   rb_valid, rb_bit    readback of shift_out, one cycle after each cen
//   busy                high whenever the loader is not IDLE
//   done, aborted       one-cycle completion / cancellation pulses
//   dbg_state           current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module baked_cb_config_loader #(
    parameter int CHAIN_LEN = 256,
    parameter int WORD      = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [WORD-1:0] word_in,
    input  logic            word_valid,
    output logic            word_ready,
    output logic            cen,
    output logic            shift_in,
    output logic            set_in,
    input  logic            shift_out,
    output logic            rb_valid,
    output logic            rb_bit,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [2:0]      dbg_state
);

    // nbits never exceeds WORD, so it only needs to count up to WORD.
    localparam int NB_W = $clog2(WORD + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SHIFT  = 3'd2,
        S_COMMIT = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bits_done;
    logic [NB_W-1:0]   nbits;
    logic [WORD-1:0]   sreg;
    logic [31:0]       remaining;
    logic [NB_W-1:0]   nbits_load;

    assign dbg_state = state;

    // Bits still owed to the chain; the last word is trimmed to this count
    // so bits_done can never run past CHAIN_LEN.
    always_comb begin
        remaining  = 32'(CHAIN_LEN) - 32'(bits_done);
        nbits_load = NB_W'(WORD);
        if (remaining < 32'(WORD)) begin
            nbits_load = NB_W'(remaining);
        end
    end

    // Every chain-facing output is a register that is updated on the same
    // edge as the state it belongs to: cen mirrors SHIFT, word_ready mirrors
    // FETCH, set_in mirrors COMMIT and done mirrors FINISH. The bit on
    // shift_in is pre-loaded when entering SHIFT and advanced each cycle, so
    // sreg only holds the bits that have not yet been presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            bits_done  <= '0;
            nbits      <= '0;
            sreg       <= '0;
            word_ready <= 1'b0;
            cen        <= 1'b0;
            shift_in   <= 1'b0;
            set_in     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            set_in  <= 1'b0;

            if (abort && (state != S_IDLE)) begin
                // Abort wins over start, word acceptance and commit; the
                // partial word is dropped.
                state      <= S_IDLE;
                word_ready <= 1'b0;
                cen        <= 1'b0;
                shift_in   <= 1'b0;
                busy       <= 1'b0;
                aborted    <= 1'b1;
                nbits      <= '0;
                sreg       <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state      <= S_FETCH;
                            bits_done  <= '0;
                            word_ready <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end

                    S_FETCH: begin
                        if (word_valid && word_ready) begin
                            state      <= S_SHIFT;
                            word_ready <= 1'b0;
                            cen        <= 1'b1;
                            shift_in   <= word_in[0];
                            sreg       <= word_in >> 1;
                            nbits      <= nbits_load;
                        end
                    end

                    S_SHIFT: begin
                        bits_done <= bits_done + CNT_W'(1);
                        nbits     <= nbits - NB_W'(1);
                        if (nbits == NB_W'(1)) begin
                            // Last bit of this word is on shift_in now.
                            cen      <= 1'b0;
                            shift_in <= 1'b0;
                            if (bits_done == LAST_IDX) begin
                                state  <= S_COMMIT;
                                set_in <= 1'b1;
                            end else begin
                                state      <= S_FETCH;
                                word_ready <= 1'b1;
                            end
                        end else begin
                            shift_in <= sreg[0];
                            sreg     <= sreg >> 1;
                        end
                    end

                    S_COMMIT: begin
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end

                    S_FINISH: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state      <= S_IDLE;
                        word_ready <= 1'b0;
                        cen        <= 1'b0;
                        shift_in   <= 1'b0;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Readback: whatever the chain tail shows during a shift cycle is
    // returned on the following cycle, independent of the load FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_valid <= 1'b0;
            rb_bit   <= 1'b0;
        end else begin
            rb_valid <= cen;
            if (cen) begin
                rb_bit <= shift_out;
            end
        end
    end

endmodule

// File: tb/tb_baked_cb_config_loader.sv
// Bench for baked_cb_config_loader with a 10-bit chain and 4-bit words.
// The chain itself is modelled here; its tail feeds shift_out.
module tb_baked_cb_config_loader;

    localparam int CL = 10;
    localparam int WD = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [WD-1:0] word_in;
    logic          word_valid;
    logic          word_ready;
    logic          cen;
    logic          shift_in;
    logic          set_in;
    logic          shift_out;
    logic          rb_valid;
    logic          rb_bit;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [2:0]    dbg_state;

    baked_cb_config_loader #(.CHAIN_LEN(CL), .WORD(WD)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
        .cen(cen), .shift_in(shift_in), .set_in(set_in), .shift_out(shift_out),
        .rb_valid(rb_valid), .rb_bit(rb_bit), .busy(busy), .done(done),
        .aborted(aborted), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- chain model ----------------
    logic [CL-1:0] chain = '0;
    logic          preload_req = 1'b0;
    logic [CL-1:0] preload_val = '0;

    always @(posedge clk) begin
        if (preload_req) chain <= preload_val;
        else if (cen)    chain <= {shift_in, chain[CL-1:1]};
    end
    assign shift_out = chain[0];

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [0:0]    sh_q[$];
    logic [0:0]    rb_q[$];
    logic [CL-1:0] cfg_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int cyc = 0;
    int last_cen_cyc = -10;
    int set_cyc = -10;

    always @(negedge clk) begin
        if (!rst) begin
            if (set_in) begin
                check("set_excl_cen", cen, 0);
                check("set_after_last_cen", cyc - last_cen_cyc, 1);
                check("set_all_shifted", sh_q.size(), 0);
                check("commit_expected", cfg_q.size() != 0, 1);
                if (cfg_q.size() != 0) check("commit_cfg", chain, cfg_q.pop_front());
                set_cyc = cyc;
            end
            if (done) check("done_after_set", cyc - set_cyc, 1);
            if (rb_valid) begin
                check("rb_after_cen", cyc - last_cen_cyc, 1);
                check("rb_expected", rb_q.size() != 0, 1);
                if (rb_q.size() != 0) check("rb_bit", rb_bit, rb_q.pop_front());
            end
            if (cen) begin
                check("shift_expected", sh_q.size() != 0, 1);
                if (sh_q.size() != 0) check("shift_in", shift_in, sh_q.pop_front());
                last_cen_cyc = cyc;
            end
        end
        cyc++;
    end

    // ---------------- driver ----------------
    int load_cen, load_ready, load_done, load_set, abort_at_g;
    bit abort_pending, abort_fired;

    // Advance to the next falling edge, keep per-load counts and fire /
    // verify a requested abort.
    task automatic tick();
        @(negedge clk);
        if (abort_pending) begin
            check("abort_cen_low", cen, 0);
            check("abort_pulse", aborted, 1);
            check("abort_busy_low", busy, 0);
            check("abort_ready_low", word_ready, 0);
            check("abort_state_idle", dbg_state, 0);
            abort = 1'b0;
            abort_pending = 0;
            abort_fired = 1;
        end
        if (cen)        load_cen++;
        if (word_ready) load_ready++;
        if (done)       load_done++;
        if (set_in)     load_set++;
        if (abort_at_g != 0 && !abort_fired && !abort_pending && cen && load_cen == abort_at_g) begin
            abort = 1'b1;
            abort_pending = 1;
        end
    endtask

    task automatic present_word(input logic [WD-1:0] w, output bit got);
        word_in = w;
        word_valid = 1'b1;
        got = 0;
        for (int t = 0; t < 60 && !got && !abort_pending && !abort_fired; t++) begin
            got = word_ready;
            tick();
        end
        word_valid = 1'b0;
    endtask

    task automatic run_load(input logic [WD-1:0] w0, input logic [WD-1:0] w1, input logic [WD-1:0] w2,
                            input logic [CL-1:0] pre, input int gap, input int ab,
                            input bit hold, input bit chk_ready);
        logic [WD-1:0]   w[3];
        logic [3*WD-1:0] cat;
        logic [CL-1:0]   cfg;
        int n;
        bit got;
        w[0] = w0; w[1] = w1; w[2] = w2;
        cat = {w2, w1, w0};
        cfg = cat[CL-1:0];
        abort_at_g = ab; abort_fired = 0; abort_pending = 0;
        tick();
        preload_val = pre;
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
        n = (ab != 0) ? ab : CL;
        for (int i = 0; i < n; i++) begin
            sh_q.push_back(cfg[i]);
            rb_q.push_back(pre[i]);
        end
        if (ab == 0) cfg_q.push_back(cfg);
        load_cen = 0; load_ready = 0; load_done = 0; load_set = 0;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int k = 0; k < 3 && !abort_pending && !abort_fired; k++) begin
            for (int g = 0; g < gap; g++) tick();
            present_word(w[k], got);
            if (!abort_pending && !abort_fired) check("word_accepted", got, 1);
        end
        if (ab != 0) begin
            for (int t = 0; t < 60 && !abort_fired; t++) tick();
            check("abort_seen", abort_fired, 1);
            tick();
            check("aborted_one_cycle", aborted, 0);
            repeat (4) tick();
            check("abort_cen_cycles", load_cen, ab);
            check("abort_no_set", load_set, 0);
            check("abort_no_done", load_done, 0);
        end else begin
            got = 0;
            for (int t = 0; t < 80 && !got; t++) begin
                tick();
                got = done;
            end
            check("done_seen", got, 1);
            tick();
            check("idle_after_done", busy, 0);
            check("cen_cycles", load_cen, CL);
            check("set_pulses", load_set, 1);
            check("done_pulses", load_done, 1);
            if (chk_ready) check("ready_cycles", load_ready, 3);
        end
        check("sh_q_drained", sh_q.size(), 0);
        check("rb_q_drained", rb_q.size(), 0);
    endtask

    function automatic logic [WD-1:0] rw();
        return WD'($urandom_range(0, (1 << WD) - 1));
    endfunction

    function automatic logic [CL-1:0] rc();
        return CL'($urandom);
    endfunction

    task automatic reset_mid_shift();
        logic [WD-1:0] w;
        bit got;
        w = rw();
        abort_at_g = 0; abort_fired = 0; abort_pending = 0;
        tick();
        preload_val = rc();
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
        for (int i = 0; i < WD; i++) begin
            sh_q.push_back(w[i]);
            rb_q.push_back(preload_val[i]);
        end
        load_cen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        present_word(w, got);
        check("rst_test_accept", got, 1);
        for (int t = 0; t < 20 && load_cen < 3; t++) tick();
        check("rst_test_shifting", cen, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_cen", cen, 0);
        check("rst_shift_in", shift_in, 0);
        check("rst_set_in", set_in, 0);
        check("rst_word_ready", word_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_aborted", aborted, 0);
        check("rst_rb_valid", rb_valid, 0);
        check("rst_rb_bit", rb_bit, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        sh_q.delete();
        rb_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; word_in = '0; word_valid = 1'b0;
        abort_at_g = 0; abort_pending = 0; abort_fired = 0;
        repeat (2) @(negedge clk);
        check("reset_cen", cen, 0);
        check("reset_word_ready", word_ready, 0);
        check("reset_set_in", set_in, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rb_valid", rb_valid, 0);
        check("reset_state", dbg_state, 0);
        rst = 1'b0;

        // abort while idle does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_no_pulse", aborted, 0);
        check("idle_abort_busy", busy, 0);

        // directed load with the known preload, back-to-back words
        run_load(4'hA, 4'h5, 4'h3, 10'b1111000011, 0, 0, 0, 1);
        // same words with idle gaps between them
        run_load(4'hA, 4'h5, 4'h3, rc(), 3, 0, 0, 0);
        // random loads
        repeat (4) run_load(rw(), rw(), rw(), rc(), int'($urandom_range(0, 2)), 0, 0, 0);
        // abort on the 6th shift, then a normal load
        run_load(rw(), rw(), rw(), rc(), 0, 6, 0, 0);
        run_load(rw(), rw(), rw(), rc(), 0, 0, 0, 1);
        // asynchronous reset mid-shift, then a clean load
        reset_mid_shift();
        run_load(rw(), rw(), rw(), rc(), 1, 0, 0, 0);
        // start held through a load, re-sampled in IDLE for the next one
        run_load(rw(), rw(), rw(), rc(), 0, 0, 1, 1);
        run_load(rw(), rw(), rw(), rc(), 0, 0, 0, 0);

        repeat (5) tick();
        check("final_sh_q_empty", sh_q.size(), 0);
        check("final_rb_q_empty", rb_q.size(), 0);
        check("final_cfg_q_empty", cfg_q.size(), 0);
        check("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
